cv32e41s_div: RTL

Iterative radix-2 integer divider for the EX stage, the inverse counterpart of the EX multiplier. It executes RV32M DIV, DIVU, REM and REMU with the same valid/ready handshake and kill semantics as the multiplier. Operands are held stable by the ID/EX pipeline register for the whole operation. Results go to the EX result mux.

---
 rtl/cv32e41s_div.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cv32e41s_div.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Shares the multiplier's valid/ready handshake; dropping valid_i kills any operation.
package cv32e41s_div_pkg;
   typedef enum logic [1:0] {
      DIV_DIV  = 2'b00,
      DIV_DIVU = 2'b01,
      DIV_REM  = 2'b10,
      DIV_REMU = 2'b11
   } div_opcode_e;
endpackage

module cv32e41s_div
   import cv32e41s_div_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_i,
   input  div_opcode_e operator_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   output logic [31:0] result_o,
   output logic        ready_o,
   output logic        valid_o,
   input  logic        ready_i
);

   typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [32:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] div_q, div_d;
   logic        neg_q_q, neg_q_d;
   logic        neg_r_q, neg_r_d;
   logic        dbz_q, dbz_d;
   logic [31:0] dvd_q, dvd_d;

   logic        op_signed;
   logic        op_rem;
   logic [33:0] rem_sh;
   logic [33:0] diff;
   logic [31:0] res_quo;
   logic [31:0] res_rem;

   // Two's-complement magnitude; 0x80000000 maps to itself and is then read as unsigned.
   function automatic logic [31:0] abs_op(input logic [31:0] v, input logic sgn);
      logic signed [31:0] sv;
      sv = signed'(v);
      return (sgn && sv < 0) ? unsigned'(-sv) : v;
   endfunction

   function automatic logic [31:0] neg_cond(input logic [31:0] v, input logic neg);
      logic signed [31:0] sv;
      sv = signed'(v);
      return neg ? unsigned'(-sv) : v;
   endfunction

   assign op_signed = (operator_i == DIV_DIV) || (operator_i == DIV_REM);
   assign op_rem    = (operator_i == DIV_REM) || (operator_i == DIV_REMU);

   // One extra guard bit so the sign of the trial subtraction is always bit 33.
   assign rem_sh = {rem_q, quo_q[31]};
   assign diff   = rem_sh - {2'b00, div_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      div_d   = div_q;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      dbz_d   = dbz_q;
      dvd_d   = dvd_q;

      if (!valid_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               quo_d   = abs_op(op_a_i, op_signed);
               div_d   = abs_op(op_b_i, op_signed);
               rem_d   = '0;
               neg_q_d = op_signed & (op_a_i[31] ^ op_b_i[31]);
               neg_r_d = op_signed & op_a_i[31];
               dvd_d   = op_a_i;
               if (op_b_i == 32'd0) begin
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  dbz_d   = 1'b0;
                  cnt_d   = 5'd31;
                  state_d = DIV;
               end
            end
            DIV: begin
               if (!diff[33]) begin
                  rem_d = diff[32:0];
                  quo_d = {quo_q[30:0], 1'b1};
               end else begin
                  rem_d = rem_sh[32:0];
                  quo_d = {quo_q[30:0], 1'b0};
               end
               if (cnt_q == 5'd0) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            DONE: begin
               if (ready_i) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         div_q   <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         dbz_q   <= 1'b0;
         dvd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         div_q   <= div_d;
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
         dbz_q   <= dbz_d;
         dvd_q   <= dvd_d;
      end
   end

   assign res_quo = dbz_q ? 32'hFFFF_FFFF : neg_cond(quo_q, neg_q_q);
   assign res_rem = dbz_q ? dvd_q : neg_cond(rem_q[31:0], neg_r_q);

   assign valid_o  = valid_i && (state_q == DONE);
   assign result_o = valid_o ? (op_rem ? res_rem : res_quo) : 32'd0;

   always_comb begin
      ready_o = 1'b1;
      if (valid_i) begin
         case (state_q)
            IDLE:    ready_o = 1'b0;
            DIV:     ready_o = 1'b0;
            DONE:    ready_o = ready_i;
            default: ready_o = 1'b0;
         endcase
      end
   end

endmodule
